// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the CPU fetch/load-store paths, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_w_i_h;
  logic [ADDR_W-1:0] if_addr_w_i;
  logic              if_gnt_w_o_h;
  logic              if_rvalid_w_o_h;
  logic [DATA_W-1:0] if_rdata_w_o;

  logic              d_req_w_i_h;
  logic              d_we_w_i_h;
  logic [ADDR_W-1:0] d_addr_w_i;
  logic [DATA_W-1:0] d_wdata_w_i;
  logic [1:0]        d_byte_sel_w_i;
  logic              d_gnt_w_o_h;
  logic              d_rvalid_w_o_h;
  logic [DATA_W-1:0] d_rdata_w_o;

  logic              mem_req_w_o_h;
  logic              mem_we_w_o_h;
  logic [ADDR_W-1:0] mem_addr_w_o;
  logic [DATA_W-1:0] mem_wdata_w_o;
  logic [1:0]        mem_byte_sel_w_o;
  logic              mem_ack_w_i_h;
  logic [DATA_W-1:0] mem_rdata_w_i;

  logic              stall_w_o_h;
  logic              err_w_o_h;

  modport slave (
    input  if_req_w_i_h, if_addr_w_i,
    output if_gnt_w_o_h, if_rvalid_w_o_h, if_rdata_w_o,
    input  d_req_w_i_h, d_we_w_i_h, d_addr_w_i, d_wdata_w_i, d_byte_sel_w_i,
    output d_gnt_w_o_h, d_rvalid_w_o_h, d_rdata_w_o,
    output mem_req_w_o_h, mem_we_w_o_h, mem_addr_w_o, mem_wdata_w_o, mem_byte_sel_w_o,
    input  mem_ack_w_i_h, mem_rdata_w_i,
    output stall_w_o_h, err_w_o_h
  );

  modport master (
    output if_req_w_i_h, if_addr_w_i,
    input  if_gnt_w_o_h, if_rvalid_w_o_h, if_rdata_w_o,
    output d_req_w_i_h, d_we_w_i_h, d_addr_w_i, d_wdata_w_i, d_byte_sel_w_i,
    input  d_gnt_w_o_h, d_rvalid_w_o_h, d_rdata_w_o,
    input  mem_req_w_o_h, mem_we_w_o_h, mem_addr_w_o, mem_wdata_w_o, mem_byte_sel_w_o,
    output mem_ack_w_i_h, mem_rdata_w_i,
    input  stall_w_o_h, err_w_o_h
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch vs load/store onto one single-port memory, alternating priority on contention.
// Latency: grant 1 cycle after request, rvalid 1 cycle after mem ack; all outputs registered.
// Backpressure: stall held for the whole busy window; MEM_ARB_TIMEOUT_EN adds a busy-cycle abort.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_w_i,
  input  logic             res_w_i_l,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state;
  logic   last_d;
  logic   pick_d;
  logic   pick_i;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  // Data wins a tie unless it also won the previous grant.
  assign pick_d = bus.d_req_w_i_h && (!bus.if_req_w_i_h || !last_d);
  assign pick_i = bus.if_req_w_i_h && !pick_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] busy_cnt;
  logic        err_q;
  assign bus.err_w_o_h = err_q;
`else
  assign bus.err_w_o_h = 1'b0;
`endif

  always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
    if (!res_w_i_l) begin
      state                <= IDLE;
      last_d               <= 1'b0;
      bus.if_gnt_w_o_h     <= 1'b0;
      bus.if_rvalid_w_o_h  <= 1'b0;
      bus.if_rdata_w_o     <= {DATA_W{1'b0}};
      bus.d_gnt_w_o_h      <= 1'b0;
      bus.d_rvalid_w_o_h   <= 1'b0;
      bus.d_rdata_w_o      <= {DATA_W{1'b0}};
      bus.mem_req_w_o_h    <= 1'b0;
      bus.mem_we_w_o_h     <= 1'b0;
      bus.mem_addr_w_o     <= {ADDR_W{1'b0}};
      bus.mem_wdata_w_o    <= {DATA_W{1'b0}};
      bus.mem_byte_sel_w_o <= 2'b00;
      bus.stall_w_o_h      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      busy_cnt             <= 16'd0;
      err_q                <= 1'b0;
`endif
    end else begin
      bus.if_gnt_w_o_h    <= 1'b0;
      bus.d_gnt_w_o_h     <= 1'b0;
      bus.if_rvalid_w_o_h <= 1'b0;
      bus.d_rvalid_w_o_h  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q               <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_d) begin
            state                <= BUSY_D;
            last_d               <= 1'b1;
            bus.d_gnt_w_o_h      <= 1'b1;
            bus.mem_req_w_o_h    <= 1'b1;
            bus.mem_we_w_o_h     <= bus.d_we_w_i_h;
            bus.mem_addr_w_o     <= bus.d_addr_w_i;
            bus.mem_wdata_w_o    <= bus.d_wdata_w_i;
            bus.mem_byte_sel_w_o <= bus.d_byte_sel_w_i;
            bus.stall_w_o_h      <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            busy_cnt             <= 16'd0;
`endif
          end else if (pick_i) begin
            state                <= BUSY_I;
            last_d               <= 1'b0;
            bus.if_gnt_w_o_h     <= 1'b1;
            bus.mem_req_w_o_h    <= 1'b1;
            bus.mem_we_w_o_h     <= 1'b0;
            bus.mem_addr_w_o     <= bus.if_addr_w_i;
            bus.mem_wdata_w_o    <= {DATA_W{1'b0}};
            bus.mem_byte_sel_w_o <= 2'b00;
            bus.stall_w_o_h      <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            busy_cnt             <= 16'd0;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_ack_w_i_h) begin
            if (state == BUSY_I) begin
              bus.if_rdata_w_o    <= bus.mem_rdata_w_i;
              bus.if_rvalid_w_o_h <= 1'b1;
            end else begin
              // Stores leave the last load result visible.
              if (!bus.mem_we_w_o_h) bus.d_rdata_w_o <= bus.mem_rdata_w_i;
              bus.d_rvalid_w_o_h <= 1'b1;
            end
            bus.mem_req_w_o_h <= 1'b0;
            bus.stall_w_o_h   <= 1'b0;
            state             <= IDLE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (busy_cnt == TIMEOUT_LAST) begin
            if (state == BUSY_I) begin
              bus.if_rdata_w_o    <= {DATA_W{1'b1}};
              bus.if_rvalid_w_o_h <= 1'b1;
            end else begin
              bus.d_rdata_w_o    <= {DATA_W{1'b1}};
              bus.d_rvalid_w_o_h <= 1'b1;
            end
            err_q             <= 1'b1;
            bus.mem_req_w_o_h <= 1'b0;
            bus.stall_w_o_h   <= 1'b0;
            state             <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and a randomized run
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_w_i   (clk),
    .res_w_i_l (rst_n),
    .bus       (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit ir, dr, ack;
    bit gi, gd, ri, rd, mr, we;
  } vec_t;

  vec_t tbl[16];

  // Transaction-level model state: which requester owns the memory and for how long.
  int          m_owner;   // 0 none, 1 fetch, 2 data
  int          m_age;
  bit          m_last_d;
  logic [31:0] m_rd_i, m_rd_d, m_addr, m_wdata;
  bit          m_we;
  logic [1:0]  m_bsel;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {bus.if_gnt_w_o_h, bus.d_gnt_w_o_h, bus.if_rvalid_w_o_h, bus.d_rvalid_w_o_h,
            bus.mem_req_w_o_h, bus.stall_w_o_h, bus.err_w_o_h};
  endfunction

  function automatic vec_t mk(bit ir, bit dr, bit ack, bit gi, bit gd, bit ri, bit rd, bit mr, bit we);
    vec_t v;
    v.ir = ir; v.dr = dr; v.ack = ack;
    v.gi = gi; v.gd = gd; v.ri = ri; v.rd = rd; v.mr = mr; v.we = we;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_w_i_h   = 1'b0;
    bus.if_addr_w_i    = '0;
    bus.d_req_w_i_h    = 1'b0;
    bus.d_we_w_i_h     = 1'b0;
    bus.d_addr_w_i     = '0;
    bus.d_wdata_w_i    = '0;
    bus.d_byte_sel_w_i = 2'b00;
    bus.mem_ack_w_i_h  = 1'b0;
    bus.mem_rdata_w_i  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'(ctl()), 64'd0);
    check({tag, "_mem"}, {bus.mem_addr_w_o, bus.mem_wdata_w_o}, 64'd0);
    check({tag, "_we_bsel"}, 64'({bus.mem_we_w_o_h, bus.mem_byte_sel_w_o}), 64'd0);
    check({tag, "_rdata"}, {bus.if_rdata_w_o, bus.d_rdata_w_o}, 64'd0);
  endtask

  // Advances the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge(output bit gi, output bit gd, output bit ri, output bit rd, output bit er);
    gi = 0; gd = 0; ri = 0; rd = 0; er = 0;
    if (m_owner != 0) begin
      m_age++;
      if (bus.mem_ack_w_i_h) begin
        if (m_owner == 1) begin m_rd_i = bus.mem_rdata_w_i; ri = 1; end
        else begin if (!m_we) m_rd_d = bus.mem_rdata_w_i; rd = 1; end
        m_owner = 0;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (m_age == TO) begin
        if (m_owner == 1) begin m_rd_i = '1; ri = 1; end
        else begin m_rd_d = '1; rd = 1; end
        er = 1;
        m_owner = 0;
      end
`endif
    end else if (bus.if_req_w_i_h || bus.d_req_w_i_h) begin
      if (bus.d_req_w_i_h && !(bus.if_req_w_i_h && m_last_d)) begin
        m_owner = 2; m_we = bus.d_we_w_i_h; m_addr = bus.d_addr_w_i;
        m_wdata = bus.d_wdata_w_i; m_bsel = bus.d_byte_sel_w_i; m_last_d = 1; gd = 1;
      end else begin
        m_owner = 1; m_we = 0; m_addr = bus.if_addr_w_i;
        m_wdata = '0; m_bsel = 2'b00; m_last_d = 0; gi = 1;
      end
      m_age = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    bit done, seen;
    int alt_exp[8];

    tbl[0]  = mk(1,0,0, 1,0,0,0,1,0);
    tbl[1]  = mk(0,0,1, 0,0,1,0,0,0);
    tbl[2]  = mk(0,0,0, 0,0,0,0,0,0);
    tbl[3]  = mk(0,0,1, 0,0,0,0,0,0);
    tbl[4]  = mk(1,1,0, 0,1,0,0,1,1);
    tbl[5]  = mk(1,0,1, 0,0,0,1,0,0);
    tbl[6]  = mk(1,1,0, 1,0,0,0,1,0);
    tbl[7]  = mk(0,1,1, 0,0,1,0,0,0);
    tbl[8]  = mk(0,1,0, 0,1,0,0,1,1);
    tbl[9]  = mk(0,0,0, 0,0,0,0,1,1);
    tbl[10] = mk(0,0,0, 0,0,0,0,1,1);
    tbl[11] = mk(0,0,1, 0,0,0,1,0,0);
    tbl[12] = mk(1,1,0, 1,0,0,0,1,0);
    tbl[13] = mk(0,1,1, 0,0,1,0,0,0);
    tbl[14] = mk(0,1,0, 0,1,0,0,1,1);
    tbl[15] = mk(0,0,1, 0,0,0,1,0,0);
    alt_exp = '{2, 0, 1, 0, 2, 0, 1, 0};

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Vector table
    bus.if_addr_w_i = 32'h100; bus.d_addr_w_i = 32'h2000; bus.d_we_w_i_h = 1'b1;
    bus.d_wdata_w_i = 32'hCAFEF00D; bus.d_byte_sel_w_i = 2'b10; bus.mem_rdata_w_i = 32'h00A00093;
    for (int i = 0; i < 16; i++) begin
      bus.if_req_w_i_h = tbl[i].ir; bus.d_req_w_i_h = tbl[i].dr; bus.mem_ack_w_i_h = tbl[i].ack;
      tick();
      check($sformatf("vec%0d", i), 64'(ctl()),
            64'({tbl[i].gi, tbl[i].gd, tbl[i].ri, tbl[i].rd, tbl[i].mr, tbl[i].mr, 1'b0}));
      if (tbl[i].mr) check($sformatf("vec%0d_we", i), 64'(bus.mem_we_w_o_h), 64'(tbl[i].we));
    end

    // Both requests held, ack always high: D,I,D,I one grant every 2 cycles
    do_reset();
    bus.if_req_w_i_h = 1; bus.d_req_w_i_h = 1; bus.mem_ack_w_i_h = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("alt%0d", i), 64'({bus.d_gnt_w_o_h, bus.if_gnt_w_o_h}), 64'(alt_exp[i]));
    end
    idle_inputs();
    tick(); tick();

    // Load to seed d_rdata, then store must leave it unchanged
    bus.d_req_w_i_h = 1; bus.d_we_w_i_h = 0; bus.d_addr_w_i = 32'h40; bus.d_byte_sel_w_i = 2'b10;
    tick();
    check("ld_gnt", 64'({bus.d_gnt_w_o_h, bus.mem_we_w_o_h}), 64'b10);
    bus.d_req_w_i_h = 0; bus.mem_ack_w_i_h = 1; bus.mem_rdata_w_i = 32'h11112222;
    tick();
    check("ld_data", {31'd0, bus.d_rvalid_w_o_h, bus.d_rdata_w_o}, {31'd0, 1'b1, 32'h11112222});
    bus.mem_ack_w_i_h = 0;
    tick();
    bus.d_req_w_i_h = 1; bus.d_we_w_i_h = 1; bus.d_addr_w_i = 32'h2000;
    bus.d_wdata_w_i = 32'hCAFEF00D; bus.d_byte_sel_w_i = 2'b10;
    tick();
    check("st_addr_wdata", {bus.mem_addr_w_o, bus.mem_wdata_w_o}, {32'h2000, 32'hCAFEF00D});
    check("st_ctl", 64'({bus.d_gnt_w_o_h, bus.mem_req_w_o_h, bus.mem_we_w_o_h, bus.mem_byte_sel_w_o, bus.stall_w_o_h}),
          64'b111101);
    bus.d_req_w_i_h = 0; bus.mem_ack_w_i_h = 1; bus.mem_rdata_w_i = 32'hDEADBEEF;
    tick();
    check("st_done", 64'({bus.d_rvalid_w_o_h, bus.mem_req_w_o_h, bus.stall_w_o_h}), 64'b100);
    check("st_rdata_kept", 64'(bus.d_rdata_w_o), 64'h11112222);
    bus.mem_ack_w_i_h = 0;
    tick();

    // Fetch alone, ack next cycle
    bus.if_req_w_i_h = 1; bus.if_addr_w_i = 32'h100;
    tick();
    check("if_gnt", 64'({bus.if_gnt_w_o_h, bus.mem_req_w_o_h, bus.mem_we_w_o_h, bus.mem_byte_sel_w_o}), 64'b11000);
    check("if_addr_wdata", {bus.mem_addr_w_o, bus.mem_wdata_w_o}, {32'h100, 32'h0});
    bus.if_req_w_i_h = 0; bus.mem_ack_w_i_h = 1; bus.mem_rdata_w_i = 32'h00A00093;
    tick();
    check("if_rvalid", {30'd0, bus.if_rvalid_w_o_h, bus.if_gnt_w_o_h, bus.if_rdata_w_o},
          {30'd0, 2'b10, 32'h00A00093});
    bus.mem_ack_w_i_h = 0;
    tick();
    check("if_rvalid_pulse", 64'(bus.if_rvalid_w_o_h), 64'd0);

    // Ack delayed 5 cycles: six busy cycles then a single rvalid
    bus.d_req_w_i_h = 1; bus.d_we_w_i_h = 0; bus.d_addr_w_i = 32'h300;
    tick();
    bus.d_req_w_i_h = 0;
    busy = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.mem_req_w_o_h && bus.stall_w_o_h) busy++;
      bus.mem_ack_w_i_h = (busy == 6);
      bus.mem_rdata_w_i = 32'h55AA33CC;
      tick();
      if (bus.d_rvalid_w_o_h) done = 1;
    end
    check("dly_busy", 64'(busy), 64'd6);
    check("dly_rvalid", {31'd0, done, bus.d_rdata_w_o}, {31'd0, 1'b1, 32'h55AA33CC});
    bus.mem_ack_w_i_h = 0;
    tick();
    check("dly_after", 64'(ctl()), 64'd0);

    // Reset asserted while BUSY_D
    bus.d_req_w_i_h = 1; bus.d_we_w_i_h = 1;
    tick();
    check("mid_busy", 64'({bus.d_gnt_w_o_h, bus.mem_req_w_o_h}), 64'b11);
    bus.d_req_w_i_h = 0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    bus.mem_ack_w_i_h = 1;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.d_rvalid_w_o_h || bus.if_rvalid_w_o_h || bus.mem_req_w_o_h) seen = 1;
    end
    check("mid_rst_lost", 64'(seen), 64'd0);
    bus.mem_ack_w_i_h = 0; bus.d_req_w_i_h = 1; bus.d_we_w_i_h = 0;
    tick();
    check("post_rst_gnt", 64'({bus.d_gnt_w_o_h, bus.mem_req_w_o_h, bus.stall_w_o_h}), 64'b111);
    bus.d_req_w_i_h = 0; bus.mem_ack_w_i_h = 1;
    tick();
    check("post_rst_rv", 64'(bus.d_rvalid_w_o_h), 64'd1);
    bus.mem_ack_w_i_h = 0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // No ack: abort after TO busy cycles with err and all-ones data
    bus.d_req_w_i_h = 1; bus.d_we_w_i_h = 0;
    tick();
    bus.d_req_w_i_h = 0;
    busy = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.mem_req_w_o_h) busy++;
      tick();
      if (bus.d_rvalid_w_o_h) done = 1;
    end
    check("to_busy", 64'(busy), 64'(TO));
    check("to_abort", {30'd0, bus.d_rvalid_w_o_h, bus.err_w_o_h, bus.d_rdata_w_o},
          {30'd0, 2'b11, 32'hFFFFFFFF});
    tick();
    // Ack arriving on the limit cycle completes normally
    bus.d_req_w_i_h = 1;
    tick();
    bus.d_req_w_i_h = 0;
    busy = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.mem_req_w_o_h) busy++;
      bus.mem_ack_w_i_h = (busy == TO);
      bus.mem_rdata_w_i = 32'h0BADF00D;
      tick();
      if (bus.d_rvalid_w_o_h) done = 1;
    end
    check("to_ack_wins", {30'd0, bus.d_rvalid_w_o_h, bus.err_w_o_h, bus.d_rdata_w_o},
          {30'd0, 2'b10, 32'h0BADF00D});
    bus.mem_ack_w_i_h = 0;
    tick();
`endif

    // Randomized traffic against the model
    do_reset();
    m_owner = 0; m_age = 0; m_last_d = 0; m_rd_i = '0; m_rd_d = '0;
    m_addr = '0; m_wdata = '0; m_we = 0; m_bsel = 2'b00;
    for (int c = 0; c < 1500; c++) begin
      bit gi, gd, ri, rd, er;
      tick();
      model_edge(gi, gd, ri, rd, er);
      check("rnd_ctl", 64'(ctl()), 64'({gi, gd, ri, rd, m_owner != 0, m_owner != 0, er}));
      check("rnd_rdata", {bus.if_rdata_w_o, bus.d_rdata_w_o}, {m_rd_i, m_rd_d});
      if (m_owner != 0) begin
        check("rnd_mem", {bus.mem_addr_w_o, bus.mem_wdata_w_o}, {m_addr, m_wdata});
        check("rnd_mem_ctl", 64'({bus.mem_we_w_o_h, bus.mem_byte_sel_w_o}), 64'({m_we, m_bsel}));
      end
      // Requesters hold until granted, then may raise a fresh request.
      if (gi) bus.if_req_w_i_h = 0;
      else if (!bus.if_req_w_i_h && ($urandom % 3 == 0)) begin
        bus.if_req_w_i_h = 1; bus.if_addr_w_i = $urandom;
      end
      if (gd) bus.d_req_w_i_h = 0;
      else if (!bus.d_req_w_i_h && ($urandom % 3 == 0)) begin
        bus.d_req_w_i_h = 1; bus.d_we_w_i_h = 1'($urandom); bus.d_addr_w_i = $urandom;
        bus.d_wdata_w_i = $urandom; bus.d_byte_sel_w_i = 2'($urandom_range(0, 2));
      end
      bus.mem_ack_w_i_h = (m_owner != 0) ? 1'($urandom) : ($urandom % 4 == 0);
      bus.mem_rdata_w_i = $urandom;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
